ipsxe_floating_point_accdump_v1_0: RTL and testbench
====================================================

Name: ipsxe_floating_point_accdump_v1_0

Overview:
- Downstream consumer of the floating-point accumulator output stream (`o_axi4s_result_tdata` / `o_axi4s_result_tvalid`). That stream has no backpressure and no block boundaries.
- This block counts accumulator results and captures the running total on every Nth result (programmable N). It tags each capture with a block index.
- Captures are buffered in a small FIFO and presented on an AXI4-Stream master with `tready` backpressure.
- FIFO overrun is reported through a sticky flag.

Parameters:
- DATA_WIDTH, 32, float word width (sign + FLOAT_EXP_BIT + FLOAT_FRAC_BIT-1).
- FLOAT_EXP_BIT, 8, exponent width; used only by the optional NaN/Inf flag.
- CNT_W, 16, width of block-length input and sample counter.
- IDX_W, 8, width of block index tag.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW.

Ports:
- i_aclk  in  1  clock; all logic rising-edge.
- i_areset_n  in  1  reset; asynchronous assert, active-low.
- i_aclken  in  1  clock enable; no state changes when 0.
- i_axi4s_result_tdata  in  DATA_WIDTH  running float sum from the accumulator.
- i_axi4s_result_tvalid  in  1  result valid; no ready, always accepted.
- i_block_len  in  CNT_W  results per capture; 0 is treated as 1.
- i_ovf_clr  in  1  clears o_overflow.
- o_axi4s_sum_tdata  out  DATA_WIDTH  captured running total.
- o_axi4s_sum_tuser  out  IDX_W  block index of this capture.
- o_axi4s_sum_tvalid  out  1  FIFO not empty.
- i_axi4s_sum_tready  in  1  downstream ready.
- o_overflow  out  1  sticky: a capture was dropped.
- o_fifo_level  out  FIFO_AW+1  current occupancy.

Behaviour:
- Reset (async, i_areset_n=0): cnt=0, len_q=1, blk_idx=0, FIFO empty, o_axi4s_sum_tvalid=0, o_overflow=0, o_fifo_level=0. Data/tuser outputs are 0. Reset mid-block discards the partial count and all FIFO contents.
- Accepted sample: i_aclken & i_axi4s_result_tvalid.
- Effective length:
  - len_eff = max(i_block_len,1) when cnt==0; otherwise len_eff = len_q.
  - len_q <= len_eff on every accepted sample with cnt==0.
  - A length change therefore only takes effect at a block start.
- Counting and capture:
  - On an accepted sample, if cnt==len_eff-1: issue capture (push {blk_idx, tdata}), set cnt<=0, blk_idx<=blk_idx+1 (wraps modulo 2**IDX_W).
  - On any other accepted sample: cnt<=cnt+1.
- Capture latency: the captured word is visible on o_axi4s_sum_tdata one cycle after the capturing sample when the FIFO was empty (registered FWFT output).
- Pop: i_aclken & o_axi4s_sum_tvalid & i_axi4s_sum_tready.
- Push rules:
  - Push succeeds if FIFO not full, or if full and a pop occurs the same cycle.
  - Otherwise the capture is dropped: FIFO unchanged, o_overflow<=1.
  - blk_idx still increments on a dropped capture, so the gap is visible in tuser.
- Overflow clear: i_ovf_clr & i_aclken clears o_overflow. If a drop occurs in the same cycle, set wins (o_overflow=1).
- Simultaneous push and pop when empty: the output shows the pushed word next cycle; level returns to 1.
- Output stability: o_axi4s_sum_tdata/tuser/tvalid are held stable while tvalid=1 and tready=0 (AXI4-Stream rule).
- o_fifo_level is exact: +1 on push only, -1 on pop only, unchanged on push+pop.
- Arithmetic: no float arithmetic in this block. Data passes bit-exact.

Optional Feature:
- Macro: IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN.
- When defined:
  - Adds output o_nan_inf (1 bit), stored in the FIFO alongside each entry.
  - o_nan_inf=1 when the captured word's exponent field [DATA_WIDTH-2 -: FLOAT_EXP_BIT] is all ones.
  - o_nan_inf is valid with o_axi4s_sum_tvalid; reset value 0.
- When undefined: the port and FIFO bit are absent; all other behaviour is identical.

Test Plan:
- Basic capture: block_len=4, feed 8 valid results of 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000) then 5.0–8.0, tready=1. Expect two outputs: 0x40800000 with tuser=0, then 0x41000000 with tuser=1. Each appears one cycle after the 4th/8th sample.
- Length change mid-block: block_len=3, feed 1 sample, then set block_len=2 and feed 5 more. First capture occurs on sample 3; following captures occur every 2 samples (samples 5 and 7 would follow).
- Backpressure/overflow: FIFO_AW=2, tready=0, block_len=1, feed 6 samples. Expect level=4, o_overflow=1, and the FIFO holds tuser 0–3. Then raise tready and expect tuser sequence 0,1,2,3 and level 0. Pulse i_ovf_clr and expect o_overflow=0.
- Full plus simultaneous pop: FIFO full, tready=1, capture in the same cycle. Expect no drop, level stays 4, o_overflow stays 0.
- Clock enable and reset: hold i_aclken=0 with tvalid=1 for 5 cycles and expect cnt unchanged and no output. Assert i_areset_n=0 mid-block with 2 entries queued, then release. Expect tvalid=0, level=0, and the next capture tagged tuser=0 after a full block_len samples.
- NaN flag (macro defined): block_len=1, feed 0x7FC00000 and expect o_nan_inf=1. Feed 0x3F800000 and expect o_nan_inf=0.

Source files
------------

// File: rtl/ipsxe_floating_point_accdump_v1_0.sv
// ipsxe_floating_point_accdump_v1_0
//
// Purpose: taps the accumulator result stream, which has no backpressure and no block
// boundaries. It counts accepted results and captures the running total on every Nth one.
// Each capture is tagged with a block index and queued in a small FIFO. The FIFO drains
// through an AXI4-Stream master that honours tready. A capture that finds the FIFO full
// is dropped, and the drop is recorded in a sticky flag.
//
// Ports:
//   i_aclk, i_areset_n, i_aclken      clock, async active-low reset, clock enable
//   i_axi4s_result_tdata/tvalid       accumulator running sum (always accepted)
//   i_block_len                       results per capture (0 behaves as 1)
//   i_ovf_clr                         clears o_overflow
//   o_axi4s_sum_tdata/tuser/tvalid    captured total, block index, FIFO not empty
//   i_axi4s_sum_tready                downstream ready
//   o_overflow                        sticky capture-dropped flag
//   o_fifo_level                      FIFO occupancy
//   o_nan_inf                         only with IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN:
//                                     the exponent field of the entry is all ones
//
// Optional feature macro: IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN

module ipsxe_floating_point_accdump_v1_0 #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FLOAT_EXP_BIT = 8,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned IDX_W         = 8,
  parameter int unsigned FIFO_AW       = 2
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  input  logic                  i_aclken,
  input  logic [DATA_WIDTH-1:0] i_axi4s_result_tdata,
  input  logic                  i_axi4s_result_tvalid,
  input  logic [CNT_W-1:0]      i_block_len,
  input  logic                  i_ovf_clr,
  output logic [DATA_WIDTH-1:0] o_axi4s_sum_tdata,
  output logic [IDX_W-1:0]      o_axi4s_sum_tuser,
  output logic                  o_axi4s_sum_tvalid,
  input  logic                  i_axi4s_sum_tready,
`ifdef IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN
  output logic                  o_nan_inf,
`endif
  output logic                  o_overflow,
  output logic [FIFO_AW:0]      o_fifo_level
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
`ifdef IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN
  localparam int unsigned EntryW = 1 + IDX_W + DATA_WIDTH;
`else
  localparam int unsigned EntryW = IDX_W + DATA_WIDTH;
`endif
  localparam logic [CNT_W-1:0]   CntOne = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IdxOne = IDX_W'(1);
  localparam logic [FIFO_AW:0]   PtrOne = (FIFO_AW + 1)'(1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   blk_idx_q, blk_idx_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [EntryW-1:0]  mem_q [Depth];

  logic [CNT_W-1:0]   len_in;
  logic [CNT_W-1:0]   len_eff;
  logic               accept;
  logic               capture;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic               nan_hit;
  logic [EntryW-1:0]  wr_entry;
  logic [EntryW-1:0]  head;

  assign accept  = i_aclken & i_axi4s_result_tvalid;
  assign len_in  = (i_block_len == '0) ? CntOne : i_block_len;
  // A new length is only sampled at a block start; mid-block the latched length holds.
  assign len_eff = (cnt_q == '0) ? len_in : len_q;
  assign capture = accept & (cnt_q == (len_eff - CntOne));

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop   = i_aclken & ~empty & i_axi4s_sum_tready;
  // When full, a same-cycle pop frees the slot that the push then takes.
  assign push  = capture & (~full | pop);
  assign drop  = capture & full & ~pop;

  assign nan_hit = &i_axi4s_result_tdata[DATA_WIDTH-2 -: FLOAT_EXP_BIT];

`ifdef IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN
  assign wr_entry = {nan_hit, blk_idx_q, i_axi4s_result_tdata};
`else
  assign wr_entry = {blk_idx_q, i_axi4s_result_tdata};
  logic unused_nan_hit;
  assign unused_nan_hit = nan_hit;
`endif

  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    blk_idx_d  = blk_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;

    if (accept) begin
      if (cnt_q == '0) begin
        len_d = len_eff;
      end
      if (capture) begin
        cnt_d     = '0;
        // Advances even on a dropped capture, so the gap is visible in tuser.
        blk_idx_d = blk_idx_q + IdxOne;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_ovf_clr && i_aclken) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cnt_q      <= '0;
      len_q      <= CntOne;
      blk_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      blk_idx_q  <= blk_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_entry;
    end
  end

  // Head of queue comes straight from registered storage: first-word fall-through.
  assign head = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_comb begin
    o_axi4s_sum_tvalid = ~empty;
    o_axi4s_sum_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
    o_axi4s_sum_tuser  = empty ? '0 : head[DATA_WIDTH +: IDX_W];
`ifdef IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN
    o_nan_inf          = empty ? 1'b0 : head[EntryW-1];
`endif
    o_overflow         = overflow_q;
    o_fifo_level       = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: tb/tb_ipsxe_floating_point_accdump_v1_0.sv
// Directed bench for ipsxe_floating_point_accdump_v1_0. Inputs change 1 ns after the
// rising edge, and outputs are sampled at that same point.

module tb_ipsxe_floating_point_accdump_v1_0;

  logic        clk;
  logic        rst_n;
  logic        aclken;
  logic [31:0] res_tdata;
  logic        res_tvalid;
  logic [15:0] block_len;
  logic        ovf_clr;
  logic [31:0] sum_tdata;
  logic [7:0]  sum_tuser;
  logic        sum_tvalid;
  logic        sum_tready;
  logic        overflow;
  logic [2:0]  fifo_level;
`ifdef IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN
  logic        nan_inf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ipsxe_floating_point_accdump_v1_0 dut (
    .i_aclk                (clk),
    .i_areset_n            (rst_n),
    .i_aclken              (aclken),
    .i_axi4s_result_tdata  (res_tdata),
    .i_axi4s_result_tvalid (res_tvalid),
    .i_block_len           (block_len),
    .i_ovf_clr             (ovf_clr),
    .o_axi4s_sum_tdata     (sum_tdata),
    .o_axi4s_sum_tuser     (sum_tuser),
    .o_axi4s_sum_tvalid    (sum_tvalid),
    .i_axi4s_sum_tready    (sum_tready),
`ifdef IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN
    .o_nan_inf             (nan_inf),
`endif
    .o_overflow            (overflow),
    .o_fifo_level          (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic feed(input logic [31:0] d);
    res_tdata  = d;
    res_tvalid = 1'b1;
    @(posedge clk);
    #1;
    res_tvalid = 1'b0;
  endtask

  task automatic idle();
    res_tvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_d;

  initial begin
    rst_n      = 1'b0;
    aclken     = 1'b1;
    res_tdata  = '0;
    res_tvalid = 1'b0;
    block_len  = 16'd4;
    ovf_clr    = 1'b0;
    sum_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(sum_tvalid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_tdata", 64'(sum_tdata), 64'd0);
    check("rst_tuser", 64'(sum_tuser), 64'd0);
    rst_n = 1'b1;
    idle();

    // Basic capture, block_len 4
    feed(32'h3F800000);
    feed(32'h40000000);
    feed(32'h40400000);
    check("b_pre_tvalid", 64'(sum_tvalid), 64'd0);
    feed(32'h40800000);
    check("b1_tvalid", 64'(sum_tvalid), 64'd1);
    check("b1_tdata", 64'(sum_tdata), 64'h40800000);
    check("b1_tuser", 64'(sum_tuser), 64'd0);
    feed(32'h40A00000);
    check("b1_popped", 64'(sum_tvalid), 64'd0);
    feed(32'h40C00000);
    feed(32'h40E00000);
    feed(32'h41000000);
    check("b2_tdata", 64'(sum_tdata), 64'h41000000);
    check("b2_tuser", 64'(sum_tuser), 64'd1);
    check("b2_level", 64'(fifo_level), 64'd1);
    idle();
    check("b_drained", 64'(fifo_level), 64'd0);

    // Length change mid-block: 3 latched at block start, 2 thereafter
    block_len = 16'd3;
    feed(32'h00000A01);
    block_len = 16'd2;
    feed(32'h00000A02);
    check("lc_no_cap2", 64'(sum_tvalid), 64'd0);
    feed(32'h00000A03);
    check("lc_cap3_valid", 64'(sum_tvalid), 64'd1);
    check("lc_cap3_tdata", 64'(sum_tdata), 64'h00000A03);
    check("lc_cap3_tuser", 64'(sum_tuser), 64'd2);
    feed(32'h00000A04);
    check("lc_no_cap4", 64'(sum_tvalid), 64'd0);
    feed(32'h00000A05);
    check("lc_cap5_tdata", 64'(sum_tdata), 64'h00000A05);
    check("lc_cap5_tuser", 64'(sum_tuser), 64'd3);
    feed(32'h00000A06);
    check("lc_no_cap6", 64'(sum_tvalid), 64'd0);
    feed(32'h00000A07);
    check("lc_cap7_tuser", 64'(sum_tuser), 64'd4);
    idle();

    // Backpressure and overflow, from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sum_tready = 1'b0;
    block_len  = 16'd1;
    for (int i = 0; i < 6; i++) feed(32'h100 + 32'(i));
    check("ov_level", 64'(fifo_level), 64'd4);
    check("ov_flag", 64'(overflow), 64'd1);
    check("ov_head_tuser", 64'(sum_tuser), 64'd0);
    check("ov_head_tdata", 64'(sum_tdata), 64'h100);
    sum_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ov_drain_valid", 64'(sum_tvalid), 64'd1);
      check("ov_drain_tuser", 64'(sum_tuser), 64'(i));
      check("ov_drain_tdata", 64'(sum_tdata), 64'h100 + 64'(i));
      idle();
    end
    check("ov_empty_level", 64'(fifo_level), 64'd0);
    check("ov_empty_valid", 64'(sum_tvalid), 64'd0);
    check("ov_still_set", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    idle();
    ovf_clr = 1'b0;
    check("ov_cleared", 64'(overflow), 64'd0);

    // Full FIFO, capture coincident with pop: no drop
    sum_tready = 1'b0;
    for (int i = 0; i < 4; i++) feed(32'h200 + 32'(i));
    check("fp_full_level", 64'(fifo_level), 64'd4);
    sum_tready = 1'b1;
    feed(32'h000002FF);
    check("fp_level", 64'(fifo_level), 64'd4);
    check("fp_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      exp_d = (i < 3) ? 32'h201 + 32'(i) : 32'h2FF;
      check("fp_drain_tuser", 64'(sum_tuser), 64'd7 + 64'(i));
      check("fp_drain_tdata", 64'(sum_tdata), 64'(exp_d));
      idle();
    end
    check("fp_empty", 64'(fifo_level), 64'd0);

    // Clock enable low freezes counting; tag here is 11
    block_len = 16'd4;
    feed(32'h300);
    feed(32'h301);
    aclken     = 1'b0;
    res_tvalid = 1'b1;
    res_tdata  = 32'h3EE;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("ce_no_out", 64'(sum_tvalid), 64'd0);
    end
    res_tvalid = 1'b0;
    aclken     = 1'b1;
    feed(32'h302);
    check("ce_cnt_held", 64'(sum_tvalid), 64'd0);
    feed(32'h303);
    check("ce_cap_valid", 64'(sum_tvalid), 64'd1);
    check("ce_cap_tuser", 64'(sum_tuser), 64'd11);
    check("ce_cap_tdata", 64'(sum_tdata), 64'h303);
    idle();

    // Reset mid-block with two queued entries
    sum_tready = 1'b0;
    block_len  = 16'd1;
    feed(32'h400);
    feed(32'h401);
    check("rm_level2", 64'(fifo_level), 64'd2);
    block_len = 16'd3;
    feed(32'h402);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_in_rst_valid", 64'(sum_tvalid), 64'd0);
    check("rm_in_rst_level", 64'(fifo_level), 64'd0);
    #1;
    rst_n      = 1'b1;
    sum_tready = 1'b1;
    @(posedge clk);
    #1;
    feed(32'h500);
    feed(32'h501);
    check("rm_partial", 64'(sum_tvalid), 64'd0);
    feed(32'h502);
    check("rm_cap_valid", 64'(sum_tvalid), 64'd1);
    check("rm_cap_tuser", 64'(sum_tuser), 64'd0);
    check("rm_cap_tdata", 64'(sum_tdata), 64'h502);
    idle();

`ifdef IPSXE_FLOATING_POINT_ACCDUMP_NANFLAG_EN
    block_len = 16'd1;
    feed(32'h7FC00000);
    check("nan_set", 64'(nan_inf), 64'd1);
    feed(32'h3F800000);
    check("nan_clr", 64'(nan_inf), 64'd0);
    check("nan_tdata", 64'(sum_tdata), 64'h3F800000);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
